// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, scaling helpers and FSM encoding for the
// servo PWM controller.
//   DEF_*            default frame/pulse/slew parameters (25 MHz clock)
//   calc_scale()     cycles of duty per degree, truncated
//   calc_center()    duty at the 90 degree mid-point
//   state_t          command FSM state encoding
`timescale 1ns/1ps
package servo_pkg;

  localparam int unsigned DEF_PERIOD    = 32'd500000;
  localparam int unsigned DEF_MIN_PULSE = 32'd25000;
  localparam int unsigned DEF_MAX_PULSE = 32'd50000;
  localparam int unsigned DEF_STEP      = 32'd250;

  // Largest accepted angle; larger commands are clamped to it.
  localparam logic [7:0] ANGLE_MAX = 8'd180;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  function automatic logic [31:0] calc_scale(input logic [31:0] min_pulse,
                                             input logic [31:0] max_pulse);
    return (max_pulse - min_pulse) / 32'd180;
  endfunction

  function automatic logic [31:0] calc_center(input logic [31:0] min_pulse,
                                              input logic [31:0] max_pulse);
    return min_pulse + (32'd90 * calc_scale(min_pulse, max_pulse));
  endfunction

  localparam logic [31:0] DEF_SCALE  = calc_scale(DEF_MIN_PULSE, DEF_MAX_PULSE);
  localparam logic [31:0] DEF_CENTER = calc_center(DEF_MIN_PULSE, DEF_MAX_PULSE);

endpackage

// File: rtl/frame_timer.sv
// frame_timer: free-running PWM frame counter.
//   clk        clock, rising edge
//   rst        asynchronous active-high reset (counter to 0)
//   frame_end  high exactly while the counter sits at PERIOD-1
`timescale 1ns/1ps
module frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic rst,
  output logic frame_end
);

  logic [31:0] count_r;
  logic        last_s;

  assign last_s    = (count_r == (PERIOD - 32'd1));
  assign frame_end = last_s;

  // Frame counter: 0..PERIOD-1, wrapping to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (last_s) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end

endmodule

// File: rtl/servo_ctrl.sv
// servo_ctrl: converts angle commands into a slew-limited PWM duty value.
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   enable       drive pulses when high; duty_cycle reads 0 when low
//   angle_valid  command present
//   angle        commanded angle in degrees (clamped to 180)
//   angle_ready  command accepted when high (IDLE only)
//   duty_cycle   registered PWM high time, changes only on frame_end
//   period       constant PWM frame length
//   frame_end    one-cycle pulse on the last cycle of each frame
//   at_target    current duty equals target duty
`timescale 1ns/1ps
module servo_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE = DEF_MAX_PULSE,
  parameter int unsigned STEP      = DEF_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        angle_valid,
  input  logic [7:0]  angle,
  output logic        angle_ready,
  output logic [31:0] duty_cycle,
  output logic [31:0] period,
  output logic        frame_end,
  output logic        at_target
);

  localparam logic [31:0] SCALE  = calc_scale(MIN_PULSE, MAX_PULSE);
  localparam logic [31:0] CENTER = calc_center(MIN_PULSE, MAX_PULSE);

  state_t      state_r,   state_s;
  logic [7:0]  mplier_r,  mplier_s;
  logic [31:0] mcand_r,   mcand_s;
  logic [31:0] prod_r,    prod_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [31:0] target_r,  target_s;
  logic [31:0] current_r, step_s;
  logic [31:0] duty_r;
  logic        frame_end_s;
  logic        ready_s;

  frame_timer #(
    .PERIOD (PERIOD)
  ) u_frame_timer (
    .clk       (clk),
    .rst       (rst),
    .frame_end (frame_end_s)
  );

  assign ready_s     = (state_r == ST_IDLE) && !rst;
  assign angle_ready = ready_s;
  assign period      = PERIOD;
  assign frame_end   = frame_end_s;
  assign duty_cycle  = duty_r;
  assign at_target   = (current_r == target_r);

  // Command FSM next state plus the shift-add multiplier datapath.
  always_comb begin
    state_s   = state_r;
    mplier_s  = mplier_r;
    mcand_s   = mcand_r;
    prod_s    = prod_r;
    bit_cnt_s = bit_cnt_r;
    target_s  = target_r;
    case (state_r)
      ST_IDLE: begin
        if (angle_valid && ready_s) begin
          state_s   = ST_MUL;
          mplier_s  = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
          mcand_s   = SCALE;
          prod_s    = 32'd0;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        // LSB-first: add the shifted multiplicand for each set angle bit.
        if (mplier_r[0]) begin
          prod_s = prod_r + mcand_r;
        end else begin
          prod_s = prod_r;
        end
        mcand_s  = {mcand_r[30:0], 1'b0};
        mplier_s = {1'b0, mplier_r[7:1]};
        if (bit_cnt_r == 3'd7) begin
          state_s   = ST_LOAD;
          bit_cnt_s = 3'd0;
        end else begin
          bit_cnt_s = bit_cnt_r + 3'd1;
        end
      end
      ST_LOAD: begin
        target_s = MIN_PULSE + prod_r;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Command FSM state and multiplier registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mplier_r  <= 8'd0;
      mcand_r   <= 32'd0;
      prod_r    <= 32'd0;
      bit_cnt_r <= 3'd0;
      target_r  <= CENTER;
    end else begin
      state_r   <= state_s;
      mplier_r  <= mplier_s;
      mcand_r   <= mcand_s;
      prod_r    <= prod_s;
      bit_cnt_r <= bit_cnt_s;
      target_r  <= target_s;
    end
  end

  // One slew step toward the target, clipped so it never overshoots.
  always_comb begin
    step_s = current_r;
    if (target_r > current_r) begin
      if ((target_r - current_r) <= STEP) begin
        step_s = target_r;
      end else begin
        step_s = current_r + STEP;
      end
    end else begin
      if ((current_r - target_r) <= STEP) begin
        step_s = target_r;
      end else begin
        step_s = current_r - STEP;
      end
    end
  end

  // Slew and duty output update only at frame boundaries; a target loaded
  // on the same edge is seen from the following frame onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_r <= CENTER;
      duty_r    <= 32'd0;
    end else if (frame_end_s) begin
      current_r <= step_s;
      duty_r    <= enable ? step_s : 32'd0;
    end else begin
      current_r <= current_r;
      duty_r    <= duty_r;
    end
  end

endmodule

// File: tb/tb_servo_ctrl.sv
// tb_servo_ctrl: scoreboard bench for servo_ctrl with a short frame.
// Expected duty values per frame and expected targets per command are
// queued by the stimulus and popped by a monitor when the DUT produces them.
`timescale 1ns/1ps
module tb_servo_ctrl;

  localparam int unsigned T_PERIOD = 32'd4000;
  localparam int unsigned T_MIN    = 32'd1000;
  localparam int unsigned T_MAX    = 32'd1900;
  localparam int unsigned T_STEP   = 32'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        angle_valid;
  logic [7:0]  angle;
  logic        angle_ready;
  logic [31:0] duty_cycle;
  logic [31:0] period;
  logic        frame_end;
  logic        at_target;

  int err_cnt   = 0;
  int chk_cnt   = 0;
  int frame_cnt = 0;
  int cyc       = 0;
  int last_fe   = 0;
  logic prev_ready = 1'b0;

  int unsigned duty_q[$];
  int unsigned tgt_q[$];

  servo_ctrl #(
    .PERIOD    (T_PERIOD),
    .MIN_PULSE (T_MIN),
    .MAX_PULSE (T_MAX),
    .STEP      (T_STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .angle_valid (angle_valid),
    .angle       (angle),
    .angle_ready (angle_ready),
    .duty_cycle  (duty_cycle),
    .period      (period),
    .frame_end   (frame_end),
    .at_target   (at_target)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Push the duty expected at the next frame_end and wait for it.
  task automatic frame_expect(input int unsigned exp);
    int start;
    int n;
    duty_q.push_back(exp);
    start = frame_cnt;
    n = 0;
    while (frame_cnt == start && n < 4100) begin
      step();
      n++;
    end
    check_val("frame_timeout", 32'(n < 4100), 32'd1);
  endtask

  // Issue one command, queue its target, and check acceptance-to-idle latency.
  task automatic send_cmd(input logic [7:0] a, input int unsigned exp_tgt);
    int n;
    n = 0;
    while (!angle_ready && n < 50) begin
      step();
      n++;
    end
    angle_valid = 1'b1;
    angle       = a;
    tgt_q.push_back(exp_tgt);
    step();
    angle_valid = 1'b0;
    n = 0;
    while (!angle_ready && n < 20) begin
      n++;
      step();
    end
    check_val("cmd_latency", 32'(n), 32'd9);
  endtask

  // Monitor: duty after each frame_end, frame spacing, target on FSM return.
  initial begin : monitor
    logic fe_seen;
    fe_seen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fe_seen) begin
        if (duty_q.size() > 0) begin
          check_val("duty", duty_cycle, duty_q.pop_front());
        end
        frame_cnt++;
      end
      fe_seen = frame_end;
      if (rst) begin
        last_fe = cyc - 1;
      end else if (frame_end) begin
        check_val("frame_gap", 32'(cyc - last_fe), 32'd4000);
        last_fe = cyc;
      end
      if (angle_ready && !prev_ready && tgt_q.size() > 0) begin
        check_val("target", dut.target_r, tgt_q.pop_front());
      end
      prev_ready = angle_ready;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst         = 1'b1;
    enable      = 1'b1;
    angle_valid = 1'b0;
    angle       = 8'd0;

    // Reset state
    repeat (3) step();
    check_val("rst_ready",     32'(angle_ready), 32'd0);
    check_val("rst_duty",      duty_cycle,       32'd0);
    check_val("rst_frame_end", 32'(frame_end),   32'd0);
    check_val("rst_period",    period,           32'd4000);
    check_val("rst_at_target", 32'(at_target),   32'd1);
    check_val("rst_target",    dut.target_r,     32'd1450);
    tgt_q.push_back(32'd1450);
    rst = 1'b0;
    step();
    step();
    check_val("ready_after_rst", 32'(angle_ready), 32'd1);
    check_val("duty_pre_frame",  duty_cycle,       32'd0);
    frame_expect(32'd1450);
    check_val("center_at_target", 32'(at_target), 32'd1);

    // Slew from 1450 to 1900
    send_cmd(8'd180, 32'd1900);
    check_val("slew_not_at_target", 32'(at_target), 32'd0);
    frame_expect(32'd1550);
    frame_expect(32'd1650);
    frame_expect(32'd1750);
    frame_expect(32'd1850);
    check_val("slew_mid_at_target", 32'(at_target), 32'd0);
    frame_expect(32'd1900);
    check_val("slew_done_at_target", 32'(at_target), 32'd1);

    // Clamp above 180
    send_cmd(8'd255, 32'd1900);
    check_val("clamp_at_target", 32'(at_target), 32'd1);

    // Handshake: valid held through MUL with changing angle, then back-to-back
    angle_valid = 1'b1;
    angle       = 8'd0;
    tgt_q.push_back(32'd1000);
    for (int i = 1; i <= 9; i++) begin
      step();
      check_val("hs_busy", 32'(angle_ready), 32'd0);
      angle = 8'(100 + i * 10);
    end
    step();
    check_val("hs_ready_after_load", 32'(angle_ready), 32'd1);
    angle = 8'd1;
    tgt_q.push_back(32'd1005);
    step();
    check_val("hs_second_accept", 32'(angle_ready), 32'd0);
    angle_valid = 1'b0;
    n = 0;
    while (!angle_ready && n < 20) begin
      n++;
      step();
    end
    check_val("hs_second_latency", 32'(n), 32'd9);

    // Enable gating while current keeps slewing toward 1005
    frame_expect(32'd1800);
    enable = 1'b0;
    frame_expect(32'd0);
    frame_expect(32'd0);
    check_val("dis_at_target", 32'(at_target), 32'd0);
    enable = 1'b1;
    frame_expect(32'd1500);

    // LOAD coincides with frame_end: that step still heads for 1005
    repeat (3990) step();
    duty_q.push_back(32'd1400);
    send_cmd(8'd180, 32'd1900);
    frame_expect(32'd1500);

    // Reset during the fourth MUL cycle aborts the command
    angle_valid = 1'b1;
    angle       = 8'd0;
    step();
    angle_valid = 1'b0;
    step();
    step();
    step();
    tgt_q.push_back(32'd1450);
    rst = 1'b1;
    step();
    check_val("abort_ready_in_rst", 32'(angle_ready), 32'd0);
    rst = 1'b0;
    step();
    check_val("abort_ready_after", 32'(angle_ready), 32'd1);
    repeat (12) step();
    check_val("abort_target",    dut.target_r,     32'd1450);
    check_val("abort_idle",      32'(angle_ready), 32'd1);
    check_val("abort_duty_zero", duty_cycle,       32'd0);
    check_val("abort_at_target", 32'(at_target),   32'd1);
    frame_expect(32'd1450);

    check_val("duty_q_drained", 32'(duty_q.size()), 32'd0);
    check_val("tgt_q_drained",  32'(tgt_q.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/servo_ctrl.md
SERVO_CTRL -- requirements
Module: servo_ctrl

Interface
REQ-001 SHALL have parameter PERIOD, default 500000, frame length in clk cycles (20 ms at 25 MHz).
REQ-002 SHALL have parameter MIN_PULSE, default 25000, duty in cycles at angle 0.
REQ-003 SHALL have parameter MAX_PULSE, default 50000, duty in cycles at angle 180.
REQ-004 SHALL have parameter STEP, default 250, maximum duty change per frame in cycles.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  when high, pulses are driven; when low, duty_cycle output is 0.
REQ-008 SHALL have port angle_valid  input  1  command present.
REQ-009 SHALL have port angle  input  8  commanded angle in degrees.
REQ-010 SHALL have port angle_ready  output  1  high when a command can be accepted.
REQ-011 SHALL have port duty_cycle  output  32  high time for the PWM, in cycles.
REQ-012 SHALL have port period  output  32  constant PERIOD for the PWM.
REQ-013 SHALL have port frame_end  output  1  one-cycle pulse on the last cycle of each frame.
REQ-014 SHALL have port at_target  output  1  high when the current duty equals the target duty.

Function
REQ-015 SHALL define SCALE = (MAX_PULSE-MIN_PULSE)/180, with integer truncation, as an elaboration-time constant.
REQ-016 SHALL use a frame counter that runs 0..PERIOD-1 and wraps to 0; frame_end SHALL be 1 exactly when the counter equals PERIOD-1.
REQ-017 SHALL use a command FSM with states IDLE, MUL and LOAD; angle_ready SHALL be 1 only in IDLE.
REQ-018 SHALL take the IDLE->MUL transition on angle_valid&&angle_ready, latching min(angle,180) and clearing the product accumulator.
REQ-019 SHALL make MUL an iterative shift-add multiply of the latched angle by SCALE, 1 bit per cycle, for exactly 8 cycles, then go to LOAD.
REQ-020 SHALL, in LOAD, set target = MIN_PULSE + product, then return to IDLE; acceptance to the target update SHALL take 9 cycles (the 8 MUL cycles plus LOAD).
REQ-021 SHALL, on each frame_end, move current toward target: if |target-current| <= STEP then current = target, otherwise current moves by ±STEP; current SHALL never overshoot target.
REQ-022 SHALL register duty_cycle = enable ? current : 0, updating it only on frame_end so that the PWM never sees a mid-frame change.
REQ-023 SHALL make at_target a combinational comparison current==target.
REQ-024 SHALL, when LOAD and frame_end coincide, have the slew step use the pre-LOAD target; the new target takes effect on the next frame_end.
REQ-025 SHALL use 32-bit unsigned arithmetic for all duty values, with no wrap.
REQ-026 SHALL ignore angle_valid outside IDLE; a command is consumed only on a handshake.

Reset
REQ-027 SHALL, while rst is high, force: state IDLE, frame counter 0, frame_end 0, current = target = CENTER = MIN_PULSE+90*SCALE, duty_cycle 0, and angle_ready 0 while asserted.
REQ-028 SHALL, when reset is asserted mid-MUL, abort the multiply with no target change; after release the FSM is in IDLE with angle_ready 1.
REQ-029 SHALL drive period = PERIOD at all times, including during reset.

Structure
REQ-030 SHALL place PERIOD/MIN/MAX/STEP defaults, SCALE, CENTER and the FSM state encoding in shared package servo_pkg.
REQ-031 SHALL use one sub-module, frame_timer (frame counter plus frame_end); the FSM and slew logic SHALL be in servo_ctrl.

Verification (PERIOD=4000, MIN_PULSE=1000, MAX_PULSE=1900, STEP=100 -> SCALE=5, CENTER=1450)
REQ-032 SHALL check reset: release rst with enable=1 -> duty_cycle 0 until first frame_end, then 1450; at_target=1; frame_end every 4000 cycles.
REQ-033 SHALL check slew: angle=180 accepted -> target 1900 after 9 cycles; duty_cycle 1550,1650,1750,1850,1900 on successive frame_end; at_target=1 after the 5th.
REQ-034 SHALL check clamp and min: angle=255 -> target 1900; angle=0 -> target 1000; angle=1 -> target 1005.
REQ-035 SHALL check handshake: angle_valid held during MUL with a changing angle -> angle_ready=0, only the first angle used; a second command is accepted in the cycle after LOAD.
REQ-036 SHALL check coincidence and abort: LOAD on the frame_end cycle -> that step uses the old target; rst pulsed in MUL cycle 4 -> target stays 1450.
REQ-037 SHALL check enable: enable=0 -> duty_cycle 0 from the next frame_end while current keeps slewing; enable=1 -> duty_cycle resumes at the current value.
